mem_responder: RTL and testbench
================================

# mem_responder

Memory-side responder for the CPU's load/store/fetch path: accepts one request at a time from the CPU's memory interface on a req/ack handshake and services it from an internal synchronous RAM, inserting a programmable number of wait states. It replaces the zero-latency combinational memory model so the control unit can be exercised against a realistic, stalling memory. Each transaction is answered with exactly one `ack` pulse carrying read data and an address-range error flag.

## Interface
- `ADDR_W`, 12: request address width (matches the instruction operand field).
- `DATA_W`, 16: data word width.
- `DEPTH`, 4096: implemented words; must be ≤ 2^ADDR_W.
- `WAIT_CYCLES`, 2: wait states inserted before the array access; 0–15.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `req`  in  1  request valid; held high by the initiator until `ack`.
- `we`  in  1  1 = write, 0 = read; sampled with `req`.
- `addr`  in  ADDR_W  word address; sampled with `req`.
- `wdata`  in  DATA_W  write data; sampled with `req`.
- `rdata`  out  DATA_W  read data; valid while `ack` = 1, held until the next read completes.
- `ack`  out  1  one-cycle completion pulse.
- `err`  out  1  qualifies `ack`: address ≥ DEPTH.
- `busy`  out  1  high in every state except IDLE.

## Operation
- FSM states: IDLE, WAIT, ACCESS, RESP.
- IDLE: `req` = 1 at an edge → capture `we`, `addr`, `wdata` into request registers; go to WAIT (load wait counter with WAIT_CYCLES−1), or ACCESS if WAIT_CYCLES = 0.
- WAIT: counter decrements each cycle; at 0 → ACCESS.
- ACCESS: in-range write → array written with captured data; in-range read → array read, result registered into `rdata`; out-of-range → no array access, `err` set, `rdata` driven to 0 for reads. → RESP.
- RESP: `ack` = 1 for exactly this cycle; → IDLE unconditionally.
- Request fields are captured once; changes on `addr`/`wdata`/`we` after acceptance are ignored.
- `req` dropped before `ack`: transaction still completes and acks (not abortable).
- `req` high in IDLE always starts a new transaction; the initiator drops `req` in the cycle after it samples `ack`.
- Write transactions leave `rdata` unchanged.
- Wait counter width 4 bits; WAIT_CYCLES > 15 is a configuration error (elaboration assertion).

## Timing
- Reset values: `ack` = 0, `err` = 0, `busy` = 0, `rdata` = 0, FSM = IDLE, counter = 0; RAM contents not reset.
- Latency: `req` sampled at edge N → `ack` high in cycle N + WAIT_CYCLES + 2 (i.e. WAIT_CYCLES + 2 cycles after acceptance; 2 cycles when WAIT_CYCLES = 0).
- Throughput: one transaction per WAIT_CYCLES + 3 cycles back-to-back (RESP → IDLE → accept).
- `busy` rises the cycle after acceptance, falls the cycle after `ack`.
- Reset asserted mid-transaction: immediate return to IDLE, `ack` not issued, a pending write not performed unless ACCESS already completed.
- Read-after-write to the same address in consecutive transactions returns the new data.

## Structure
- Package `mem_pkg`: FSM state enum (IDLE, WAIT, ACCESS, RESP), default widths `ADDR_W`/`DATA_W`, shared with the control unit.
- Sub-module `mem_array`: single-port synchronous RAM (DEPTH × DATA_W, write-enable, registered read, no reset).
- FSM, wait counter, request registers and range check live in `mem_responder`.

## Test plan
- Write then read: WAIT_CYCLES=2, write 0xBEEF to 0x010, then read 0x010 → each `ack` 4 cycles after acceptance, `rdata` = 0xBEEF, `err` = 0.
- Zero wait: WAIT_CYCLES=0, read of previously written 0x0A5A at 0x000 → `ack` 2 cycles after acceptance, `rdata` = 0x0A5A.
- Out of range: DEPTH=256, read 0x100 → `ack` with `err` = 1, `rdata` = 0; write 0x1FF of 0x1234 then read 0x0FF → original contents unchanged.
- Input churn: change `addr`/`wdata` and drop `req` during WAIT → captured transaction completes with original values, single `ack`.
- Reset mid-operation: assert `reset` low in WAIT of a write to 0x020 → `busy`/`ack` go 0 immediately, no `ack`, later read of 0x020 returns prior data.
- Back-to-back: three reads with `req` re-raised the cycle after each `ack` → acks spaced WAIT_CYCLES + 3 cycles, correct data each.

Source files
------------

// File: rtl/mem_responder_pkg.sv
// Shared definitions for the CPU memory path: responder FSM states and default bus widths.
package mem_pkg;

  localparam int MEM_ADDR_W = 12;
  localparam int MEM_DATA_W = 16;
  localparam int MEM_CNT_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WAIT   = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } mem_state_e;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-to-memory request/acknowledge bus; master is the CPU side, slave the responder.
interface mem_responder_if #(
  parameter int ADDR_W = mem_pkg::MEM_ADDR_W,
  parameter int DATA_W = mem_pkg::MEM_DATA_W
);

  logic              req;
  logic              we;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic              ack;
  logic              err;
  logic              busy;

  modport master (
    output req, we, addr, wdata,
    input  rdata, ack, err, busy
  );

  modport slave (
    input  req, we, addr, wdata,
    output rdata, ack, err, busy
  );

endinterface

// File: rtl/mem_responder_array.sv
// Single-port synchronous RAM: write-enable, registered read, contents never reset.
module mem_array #(
  parameter int DEPTH  = 4096,
  parameter int DATA_W = 16,
  parameter int AW     = 12
) (
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata_q <= mem[addr];
      end
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Stalling memory responder: captures one request, waits WAIT_CYCLES, accesses the RAM, then
// answers with a single ack pulse carrying read data and an out-of-range error flag.
module mem_responder
  import mem_pkg::*;
#(
  parameter int ADDR_W      = MEM_ADDR_W,
  parameter int DATA_W      = MEM_DATA_W,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            reset,
  mem_responder_if.slave  bus
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0]        DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [MEM_CNT_W-1:0]   CNT_INIT = (WAIT_CYCLES > 0) ? MEM_CNT_W'(WAIT_CYCLES - 1) : '0;

  localparam logic [1:0] S_IDLE   = 2'(ST_IDLE);
  localparam logic [1:0] S_WAIT   = 2'(ST_WAIT);
  localparam logic [1:0] S_ACCESS = 2'(ST_ACCESS);
  localparam logic [1:0] S_RESP   = 2'(ST_RESP);

  if (WAIT_CYCLES < 0 || WAIT_CYCLES > 15) begin : g_bad_wait
    $error("mem_responder: WAIT_CYCLES must be in 0..15");
  end
  if (DEPTH < 2 || DEPTH > (1 << ADDR_W)) begin : g_bad_depth
    $error("mem_responder: DEPTH must be in 2..2**ADDR_W");
  end

  logic [1:0]           state_q, state_d;
  logic [MEM_CNT_W-1:0] cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [DATA_W-1:0]    wdata_q, wdata_d;
  logic                 err_q, err_d;
  logic [DATA_W-1:0]    rdata_q, rdata_d;

  logic                 in_range;
  logic                 ram_en;
  logic [DATA_W-1:0]    ram_rdata;
  logic                 rd_hit;

  assign in_range = ({1'b0, addr_q} < DEPTH_L);
  assign ram_en   = (state_q == S_ACCESS) && in_range;
  // RAM data is only valid in RESP, so a good read is forwarded straight from the array then.
  assign rd_hit   = (state_q == S_RESP) && !we_q && !err_q;

  mem_array #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W),
    .AW     (AW)
  ) u_array (
    .clk   (clk),
    .en    (ram_en),
    .we    (we_q),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          we_d    = bus.we;
          addr_d  = bus.addr;
          wdata_d = bus.wdata;
          err_d   = 1'b0;
          cnt_d   = CNT_INIT;
          state_d = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          state_d = S_ACCESS;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_ACCESS: begin
        err_d = !in_range;
        if (!in_range && !we_q) begin
          rdata_d = '0;
        end
        state_d = S_RESP;
      end
      default: begin
        if (rd_hit) begin
          rdata_d = ram_rdata;
        end
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  assign bus.ack   = (state_q == S_RESP);
  assign bus.err   = (state_q == S_RESP) && err_q;
  assign bus.busy  = (state_q != S_IDLE);
  assign bus.rdata = rd_hit ? ram_rdata : rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
// Randomized and directed bench for mem_responder: two configurations against a word-array model.
module tb_mem_responder;

  localparam int AW  = 12;
  localparam int DW  = 16;
  localparam int W_A = 2;
  localparam int D_A = 256;
  localparam int W_B = 0;
  localparam int D_B = 4096;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if_a ();
  mem_responder_if #(.ADDR_W(AW), .DATA_W(DW)) if_b ();

  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D_A), .WAIT_CYCLES(W_A)) dut_a (
    .clk (clk), .reset (rst_a), .bus (if_a.slave)
  );
  mem_responder #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(D_B), .WAIT_CYCLES(W_B)) dut_b (
    .clk (clk), .reset (rst_b), .bus (if_b.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one word array per DUT plus the last rdata value each should be holding.
  logic [DW-1:0] model [2][4096];
  bit            known [2][4096];
  logic [DW-1:0] last_rd [2];
  bit            last_known [2];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic r, input logic w, input logic [AW-1:0] a,
                       input logic [DW-1:0] d);
    if (sel == 0) begin
      if_a.req = r; if_a.we = w; if_a.addr = a; if_a.wdata = d;
    end else begin
      if_b.req = r; if_b.we = w; if_b.addr = a; if_b.wdata = d;
    end
  endtask

  task automatic set_req(input int sel, input logic r);
    if (sel == 0) if_a.req = r;
    else          if_b.req = r;
  endtask

  task automatic sample(input int sel, output logic ack, output logic busy, output logic err,
                        output logic [DW-1:0] rd);
    if (sel == 0) begin
      ack = if_a.ack; busy = if_a.busy; err = if_a.err; rd = if_a.rdata;
    end else begin
      ack = if_b.ack; busy = if_b.busy; err = if_b.err; rd = if_b.rdata;
    end
  endtask

  // One complete transaction, started at a negedge with the DUT idle; returns at the negedge
  // where the DUT is idle again, so consecutive calls run back-to-back.
  task automatic txn(input int sel, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                     input bit churn, output int ack_cyc);
    int            wc    = (sel == 0) ? W_A : W_B;
    int            depth = (sel == 0) ? D_A : D_B;
    int            lat   = -1;
    int            nack  = 0;
    logic          ack, busy, e, e_s;
    logic [DW-1:0] rd, rd_s;
    bit            exp_err;
    e_s = 1'b0;
    rd_s = '0;
    ack_cyc = -1;
    drive(sel, 1'b1, w, a, d);
    @(posedge clk);
    #1;
    if (churn) drive(sel, 1'b0, ~w, a ^ 12'h5A5, DW'($urandom));
    for (int k = 1; k <= wc + 3; k++) begin
      @(negedge clk);
      sample(sel, ack, busy, e, rd);
      if (ack) begin
        nack++;
        if (lat < 0) begin
          lat = k; ack_cyc = cyc; rd_s = rd; e_s = e;
        end
        set_req(sel, 1'b0);
      end
      if (k <= wc + 2) check("busy_high", 32'(busy), 32'd1);
      else             check("busy_fall", 32'(busy), 32'd0);
    end
    check("ack_latency", 32'(lat), 32'(wc + 2));
    check("ack_count", 32'(nack), 32'd1);
    exp_err = (int'(a) >= depth);
    check("err", 32'(e_s), 32'(exp_err));
    if (w) begin
      if (last_known[sel]) check("rdata_held", 32'(rd_s), 32'(last_rd[sel]));
      if (!exp_err) begin
        model[sel][a] = d;
        known[sel][a] = 1'b1;
      end
    end else begin
      if (exp_err) begin
        check("rdata_oor", 32'(rd_s), 32'd0);
        last_rd[sel] = '0;
        last_known[sel] = 1'b1;
      end else if (known[sel][a]) begin
        check("rdata", 32'(rd_s), 32'(model[sel][a]));
        last_rd[sel] = model[sel][a];
        last_known[sel] = 1'b1;
      end else begin
        last_known[sel] = 1'b0;
      end
    end
  endtask

  initial begin
    int            t0, t1, t2;
    logic          ack, busy, e;
    logic [DW-1:0] rd;
    logic [AW-1:0] ra;

    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 4096; i++) known[s][i] = 1'b0;
      last_rd[s] = '0;
      last_known[s] = 1'b1;
    end
    rst_a = 1'b0;
    rst_b = 1'b0;
    drive(0, 1'b0, 1'b0, '0, '0);
    drive(1, 1'b0, 1'b0, '0, '0);
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      sample(s, ack, busy, e, rd);
      check("reset_ack", 32'(ack), 32'd0);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_err", 32'(e), 32'd0);
      check("reset_rdata", 32'(rd), 32'd0);
    end
    rst_a = 1'b1;
    rst_b = 1'b1;
    @(negedge clk);

    // Configuration A: two wait states, 256 implemented words.
    txn(0, 1'b1, 12'h010, 16'hBEEF, 1'b0, t0);
    txn(0, 1'b0, 12'h010, 16'h0000, 1'b0, t0);
    txn(0, 1'b0, 12'h100, 16'h0000, 1'b0, t0);
    txn(0, 1'b1, 12'h0FF, 16'h5555, 1'b0, t0);
    txn(0, 1'b1, 12'h1FF, 16'h1234, 1'b0, t0);
    txn(0, 1'b0, 12'h0FF, 16'h0000, 1'b0, t0);
    txn(0, 1'b1, 12'h030, 16'hCAFE, 1'b1, t0);
    txn(0, 1'b0, 12'h030, 16'h0000, 1'b1, t0);

    // Reset during WAIT of a write: must not ack and must not write.
    txn(0, 1'b1, 12'h020, 16'h1111, 1'b0, t0);
    drive(0, 1'b1, 1'b1, 12'h020, 16'h2222);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    rst_a = 1'b0;
    #1;
    sample(0, ack, busy, e, rd);
    check("midreset_busy", 32'(busy), 32'd0);
    check("midreset_ack", 32'(ack), 32'd0);
    drive(0, 1'b0, 1'b0, '0, '0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample(0, ack, busy, e, rd);
      check("midreset_noack", 32'(ack), 32'd0);
    end
    rst_a = 1'b1;
    last_rd[0] = '0;
    last_known[0] = 1'b1;
    @(negedge clk);
    txn(0, 1'b0, 12'h020, 16'h0000, 1'b0, t0);

    txn(0, 1'b0, 12'h010, 16'h0000, 1'b0, t0);
    txn(0, 1'b0, 12'h030, 16'h0000, 1'b0, t1);
    txn(0, 1'b0, 12'h0FF, 16'h0000, 1'b0, t2);
    check("b2b_a_gap1", 32'(t1 - t0), 32'(W_A + 3));
    check("b2b_a_gap2", 32'(t2 - t1), 32'(W_A + 3));

    // Configuration B: zero wait states, full 4096-word array.
    txn(1, 1'b1, 12'h000, 16'h0A5A, 1'b0, t0);
    txn(1, 1'b0, 12'h000, 16'h0000, 1'b0, t0);
    txn(1, 1'b1, 12'hFFF, 16'h7E57, 1'b0, t0);
    txn(1, 1'b0, 12'h000, 16'h0000, 1'b0, t0);
    txn(1, 1'b0, 12'hFFF, 16'h0000, 1'b1, t1);
    check("b2b_b_gap", 32'(t1 - t0), 32'(W_B + 3));

    // Randomized traffic on both configurations.
    for (int n = 0; n < 60; n++) begin
      ra = 12'($urandom_range(0, 319));
      txn(0, 1'($urandom), ra, DW'($urandom), ($urandom_range(0, 3) == 0), t0);
    end
    for (int n = 0; n < 60; n++) begin
      ra = ($urandom_range(0, 7) == 0) ? 12'($urandom) : 12'($urandom_range(0, 63));
      txn(1, 1'($urandom), ra, DW'($urandom), ($urandom_range(0, 3) == 0), t0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
